// File: rtl/cv32e40p_x_if_pkg.sv
// cv32e40p_x_if_pkg: shared X-interface types and constants for the result path
package cv32e40p_x_if_pkg;
    localparam int X_RESULT_BUF_DEPTH = 2;
    localparam int X_RESULT_XLEN      = 32;
    typedef struct packed {
        logic [4:0]               rd;
        logic [X_RESULT_XLEN-1:0] data;
    } x_result_entry_t;
endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// cv32e40p_x_result_fifo: generic DEPTH-entry FIFO
// ports: clk_i/rst_i clock and async high reset; push_i/wdata_i write side;
// pop_i/rdata_o read side (rdata_o is the head); full_o, empty_o, cnt_o status
module cv32e40p_x_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [3:0]       cnt_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [3:0]       cnt_q;
    // pointers wrap by compare-and-clear so non-power-of-2 depths work
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wr_ptr <= inc(wr_ptr);
            if (pop_i) rd_ptr <= inc(rd_ptr);
            cnt_q <= cnt_q + 4'(push_i) - 4'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= wdata_i;
    end
    assign rdata_o = mem[rd_ptr];
    assign full_o  = cnt_q == 4'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign cnt_o   = cnt_q;
endmodule

// File: rtl/cv32e40p_x_result_buf.sv
// cv32e40p_x_result_buf: buffers coprocessor results and retires them into free RF write slots
// ports: clk_i/rst_i clock and async high reset; x_result_* coprocessor result channel;
// rf_wb_busy_i core writeback owns the RF port; rf_* RF write port; x_rvalid_o/x_rwaddr_o
// scoreboard clear; wb_stall_req_o starvation stall request; empty_o/cnt_o occupancy
module cv32e40p_x_result_buf
    import cv32e40p_x_if_pkg::*;
#(
    parameter int DEPTH        = X_RESULT_BUF_DEPTH,
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_result_valid_i,
    output logic            x_result_ready_o,
    input  logic [4:0]      x_result_rd_i,
    input  logic [XLEN-1:0] x_result_data_i,
    input  logic            x_result_we_i,
    input  logic            rf_wb_busy_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            x_rvalid_o,
    output logic [4:0]      x_rwaddr_o,
    output logic            wb_stall_req_o,
    output logic            empty_o,
    output logic [3:0]      cnt_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic            full, empty, push, pop;
    logic [XLEN+4:0] head;
    logic [4:0]      head_rd;
    logic [SW-1:0]   starve_q;
    // results without a register writeback are consumed but never stored
    assign x_result_ready_o = ~full;
    assign push = x_result_valid_i & ~full & x_result_we_i;
    assign pop  = ~empty & ~rf_wb_busy_i;
    cv32e40p_x_result_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN + 5)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i ({x_result_rd_i, x_result_data_i}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .cnt_o   (cnt_o)
    );
    assign head_rd    = head[XLEN+4:XLEN];
    assign x_rvalid_o = pop;
    assign x_rwaddr_o = pop ? head_rd : '0;
    assign rf_we_o    = pop & (head_rd != '0);
    assign rf_waddr_o = pop ? head_rd : '0;
    assign rf_wdata_o = pop ? head[XLEN-1:0] : '0;
    assign empty_o    = empty;
    // any non-empty cycle without a pop is a blocked cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) starve_q <= '0;
        else starve_q <= (empty | pop) ? '0 : starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + 1'b1;
    end
    assign wb_stall_req_o = starve_q == SW'(STARVE_LIMIT);
endmodule

// File: tb/tb_cv32e40p_x_result_buf.sv
// tb_cv32e40p_x_result_buf: directed self-checking bench for the X result buffer
module tb_cv32e40p_x_result_buf;
    logic        clk_i = 0, rst_i = 1;
    logic        x_result_valid_i = 0, x_result_we_i = 1, rf_wb_busy_i = 0;
    logic [4:0]  x_result_rd_i = 0;
    logic [31:0] x_result_data_i = 0;
    logic        x_result_ready_o, rf_we_o, x_rvalid_o, wb_stall_req_o, empty_o;
    logic [4:0]  rf_waddr_o, x_rwaddr_o;
    logic [31:0] rf_wdata_o;
    logic [3:0]  cnt_o;
    int errors = 0, checks = 0;

    cv32e40p_x_result_buf dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
        .x_result_rd_i(x_result_rd_i), .x_result_data_i(x_result_data_i),
        .x_result_we_i(x_result_we_i), .rf_wb_busy_i(rf_wb_busy_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .x_rvalid_o(x_rvalid_o), .x_rwaddr_o(x_rwaddr_o),
        .wb_stall_req_o(wb_stall_req_o), .empty_o(empty_o), .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic we, input logic b);
        x_result_valid_i = v;
        x_result_rd_i    = rd;
        x_result_data_i  = d;
        x_result_we_i    = we;
        rf_wb_busy_i     = b;
        #1;
    endtask

    initial begin
        #1;
        chk("rst_ready", x_result_ready_o, 1);
        chk("rst_empty", empty_o, 1);
        chk("rst_cnt", cnt_o, 0);
        chk("rst_rf_we", rf_we_o, 0);
        chk("rst_rvalid", x_rvalid_o, 0);
        chk("rst_stall", wb_stall_req_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        tick(); tick();
        rst_i = 0;
        // single push, retires the following cycle with no bypass
        drv(1, 5, 32'hDEADBEEF, 1, 0);
        chk("nobypass_we", rf_we_o, 0);
        chk("nobypass_rvalid", x_rvalid_o, 0);
        tick();
        drv(0, 0, 0, 1, 0);
        chk("p1_we", rf_we_o, 1);
        chk("p1_waddr", rf_waddr_o, 5);
        chk("p1_wdata", rf_wdata_o, 32'hDEADBEEF);
        chk("p1_rvalid", x_rvalid_o, 1);
        chk("p1_rwaddr", x_rwaddr_o, 5);
        chk("p1_cnt", cnt_o, 1);
        tick();
        chk("p1_empty", empty_o, 1);
        chk("p1_rvalid_off", x_rvalid_o, 0);
        // fill while busy, then offer a third result
        drv(1, 3, 32'h33, 1, 1);
        tick();
        drv(1, 4, 32'h44, 1, 1);
        chk("busy_no_pop", x_rvalid_o, 0);
        tick();
        drv(1, 6, 32'h66, 1, 1);
        chk("full_ready", x_result_ready_o, 0);
        chk("full_cnt", cnt_o, 2);
        tick();
        chk("held_cnt", cnt_o, 2);
        drv(1, 6, 32'h66, 1, 0);
        chk("full_pop_ready", x_result_ready_o, 0);
        chk("ret3_waddr", rf_waddr_o, 3);
        chk("ret3_wdata", rf_wdata_o, 32'h33);
        tick();
        chk("nopush_full_cnt", cnt_o, 1);
        chk("ret4_ready", x_result_ready_o, 1);
        chk("ret4_waddr", rf_waddr_o, 4);
        chk("ret4_rvalid", x_rvalid_o, 1);
        tick();
        drv(0, 0, 0, 1, 0);
        chk("pushpop_cnt", cnt_o, 1);
        chk("ret6_waddr", rf_waddr_o, 6);
        chk("ret6_wdata", rf_wdata_o, 32'h66);
        tick();
        chk("drain_empty", empty_o, 1);
        // we=0 is consumed without storage
        drv(1, 9, 32'h99, 0, 0);
        chk("we0_ready", x_result_ready_o, 1);
        tick();
        drv(0, 0, 0, 1, 0);
        chk("we0_cnt", cnt_o, 0);
        chk("we0_rvalid", x_rvalid_o, 0);
        chk("we0_rf_we", rf_we_o, 0);
        // rd=0 pops and clears scoreboard but does not write the RF
        drv(1, 0, 32'h1234, 1, 0);
        tick();
        drv(0, 0, 0, 1, 0);
        chk("rd0_rvalid", x_rvalid_o, 1);
        chk("rd0_rwaddr", x_rwaddr_o, 0);
        chk("rd0_rf_we", rf_we_o, 0);
        tick();
        chk("rd0_empty", empty_o, 1);
        // starvation
        drv(1, 10, 32'hA0, 1, 1);
        tick();
        drv(0, 0, 0, 1, 1);
        tick(); tick(); tick();
        chk("starve3", wb_stall_req_o, 0);
        tick();
        chk("starve4", wb_stall_req_o, 1);
        tick(); tick();
        chk("starve6_sat", wb_stall_req_o, 1);
        drv(0, 0, 0, 1, 0);
        chk("starve_pop_we", rf_we_o, 1);
        chk("starve_pop_waddr", rf_waddr_o, 10);
        chk("starve_pop_req", wb_stall_req_o, 1);
        tick();
        chk("starve_clear", wb_stall_req_o, 0);
        chk("starve_empty", empty_o, 1);
        // reset mid-operation discards buffered entries
        drv(1, 1, 32'h11, 1, 1);
        tick();
        drv(1, 2, 32'h22, 1, 1);
        tick();
        drv(0, 0, 0, 1, 1);
        chk("pre_rst_cnt", cnt_o, 2);
        #2;
        rst_i = 1;
        drv(0, 0, 0, 1, 0);
        chk("mid_rst_cnt", cnt_o, 0);
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_rf_we", rf_we_o, 0);
        chk("mid_rst_ready", x_result_ready_o, 1);
        tick();
        rst_i = 0;
        #1;
        tick();
        chk("post_rst_cnt", cnt_o, 0);
        chk("post_rst_rvalid", x_rvalid_o, 0);
        chk("post_rst_stall", wb_stall_req_o, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
